// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches from instruction memory over a
// req/ack handshake, holds the fetched word for decode, and picks the next PC
// from the Jump/Branch decodes and the ALU Zero flag when the instruction retires.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] instr,
  output logic [5:0]  Opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Word alignment is enforced on the reset value so pc[1:0] is never nonzero.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state;
  state_t      state_next;
  logic        fetch_done;
  logic        retire;
  logic [31:0] branch_offset;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // State register; reset forces BOOT at once so req/valid drop without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; acks outside REQ never complete a fetch.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_done  = 1'b0;
    retire      = 1'b0;
    case (state)
      BOOT: begin
        state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire     = 1'b1;
          state_next = REQ;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Next PC: Jump wins over Branch (Branch may be X for J), taken branch needs Zero.
  always_comb begin
    branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    branch_target = pc_plus4 + branch_offset;
    next_pc       = pc_plus4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && Zero) begin
      next_pc = branch_target;
    end
  end

  // Instruction register: loads only on an accepted ack and survives retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= 32'h0000_0000;
    end else if (fetch_done) begin
      instr <= imem_rdata;
    end
  end

  // Program counter: only the retire edge moves it, so decode inputs elsewhere are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC_ALIGNED;
    end else if (retire) begin
      pc <= next_pc;
    end
  end

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign Opcode    = instr[31:26];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: two instances with different reset PCs
// share one stimulus stream, and a protocol-level model predicts every output.
module tb_inst_fetch;

  localparam logic [31:0] RESET_A = 32'h0000_0043;
  localparam logic [31:0] RESET_B = 32'hF000_0000;

  logic        clk;
  logic        rst;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        stall;
  logic        jump;
  logic        branch;
  logic        zero;

  logic        imemReq    [2];
  logic [31:0] imemAddr   [2];
  logic [31:0] instrOut   [2];
  logic [5:0]  opcodeOut  [2];
  logic        instrValid [2];
  logic [31:0] pcOut      [2];
  logic [31:0] pcPlus4Out [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mPc [2];
  logic [31:0] mInstr;
  logic        mValid;
  logic        mReq;
  logic        mBoot;

  inst_fetch #(.RESET_PC(RESET_A)) dutA (
    .clk(clk), .rst(rst),
    .imem_req(imemReq[0]), .imem_addr(imemAddr[0]),
    .imem_ack(imemAck), .imem_rdata(imemRdata),
    .stall(stall), .Jump(jump), .Branch(branch), .Zero(zero),
    .instr(instrOut[0]), .Opcode(opcodeOut[0]), .instr_valid(instrValid[0]),
    .pc(pcOut[0]), .pc_plus4(pcPlus4Out[0])
  );

  inst_fetch #(.RESET_PC(RESET_B)) dutB (
    .clk(clk), .rst(rst),
    .imem_req(imemReq[1]), .imem_addr(imemAddr[1]),
    .imem_ack(imemAck), .imem_rdata(imemRdata),
    .stall(stall), .Jump(jump), .Branch(branch), .Zero(zero),
    .instr(instrOut[1]), .Opcode(opcodeOut[1]), .instr_valid(instrValid[1]),
    .pc(pcOut[1]), .pc_plus4(pcPlus4Out[1])
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target of a retiring instruction computed from plain arithmetic on the ISA fields.
  function automatic logic [31:0] nextPc(input logic [31:0] p, input logic [31:0] w,
                                         input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int off;
    seq = p + 32'd4;
    if (j === 1'b1) return (seq & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
    if (b === 1'b1 && z === 1'b1) begin
      off = int'($signed(w[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Protocol model: boot cycle, request until ack, hold until unstalled, then retire.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPc[0] <= RESET_A & ~32'h3;
      mPc[1] <= RESET_B & ~32'h3;
      mInstr <= 32'h0;
      mValid <= 1'b0;
      mReq   <= 1'b0;
      mBoot  <= 1'b1;
    end else if (mBoot) begin
      mBoot <= 1'b0;
      mReq  <= 1'b1;
    end else if (mReq) begin
      if (imemAck === 1'b1) begin
        mInstr <= imemRdata;
        mReq   <= 1'b0;
        mValid <= 1'b1;
      end
    end else if (mValid && stall !== 1'b1) begin
      for (int i = 0; i < 2; i++) mPc[i] <= nextPc(mPc[i], mInstr, jump, branch, zero);
      mValid <= 1'b0;
      mReq   <= 1'b1;
    end
  end

  // Every falling edge, compare both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("pc[%0d]", i), pcOut[i], mPc[i]);
      checkOutput($sformatf("imem_addr[%0d]", i), imemAddr[i], mPc[i]);
      checkOutput($sformatf("pc_plus4[%0d]", i), pcPlus4Out[i], mPc[i] + 32'd4);
      checkOutput($sformatf("instr[%0d]", i), instrOut[i], mInstr);
      checkOutput($sformatf("Opcode[%0d]", i), {26'b0, opcodeOut[i]}, {26'b0, mInstr[31:26]});
      checkOutput($sformatf("instr_valid[%0d]", i), {31'b0, instrValid[i]}, {31'b0, mValid});
      checkOutput($sformatf("imem_req[%0d]", i), {31'b0, imemReq[i]}, {31'b0, mReq});
    end
  end

  // One complete fetch: wait for req, optional wait states, ack, optional stall, retire.
  task automatic applyStimulus(input logic [31:0] word, input int waits, input int stallCycles,
                               input logic j, input logic b, input logic z);
    int n;
    n = 0;
    while (imemReq[0] !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("req within bound", {31'b0, imemReq[0]}, 32'd1);
    repeat (waits) begin
      @(negedge clk); #1;
    end
    imemAck   = 1'b1;
    imemRdata = word;
    @(negedge clk); #1;
    imemAck   = 1'b0;
    imemRdata = 32'h1234_5678;
    checkOutput("valid after ack", {31'b0, instrValid[0]}, 32'd1);
    for (int k = 0; k < stallCycles; k++) begin
      stall  = 1'b1;
      jump   = k[0];
      branch = k[1];
      zero   = ~k[0];
      @(negedge clk); #1;
    end
    stall  = 1'b0;
    jump   = j;
    branch = b;
    zero   = z;
    @(negedge clk); #1;
    jump   = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    rst       = 1'b1;
    imemAck   = 1'b0;
    imemRdata = 32'h0;
    stall     = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset pcA", pcOut[0], 32'h0000_0040);
    checkOutput("reset pcB", pcOut[1], 32'hF000_0000);
    checkOutput("reset req", {31'b0, imemReq[0]}, 32'd0);
    checkOutput("reset valid", {31'b0, instrValid[0]}, 32'd0);
    checkOutput("reset instr", instrOut[0], 32'd0);
    rst = 1'b0;

    @(negedge clk); #1;
    checkOutput("first req", {31'b0, imemReq[0]}, 32'd1);
    checkOutput("first addr", imemAddr[0], 32'h0000_0040);

    applyStimulus(32'h0800_0000, 0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("jump to zero", pcOut[0], 32'h0000_0000);

    applyStimulus(32'h2008_0001, 3, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("seq pc 4", pcOut[0], 32'h0000_0004);
    applyStimulus(32'h0000_0020, 3, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("seq pc 8", pcOut[0], 32'h0000_0008);
    applyStimulus(32'h8C01_0004, 3, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("seq pc C", pcOut[0], 32'h0000_000C);
    checkOutput("instr kept", instrOut[0], 32'h8C01_0004);
    checkOutput("opcode lw", {26'b0, opcodeOut[0]}, 32'h23);
    checkOutput("valid cleared", {31'b0, instrValid[0]}, 32'd0);

    applyStimulus(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("jump to 100", pcOut[0], 32'h0000_0100);
    applyStimulus(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("beq taken A", pcOut[0], 32'h0000_00FC);
    checkOutput("beq taken B", pcOut[1], 32'hF000_00FC);
    applyStimulus(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("beq not taken", pcOut[0], 32'h0000_0104);

    applyStimulus(32'h0800_0000, 0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("B at F0000000", pcOut[1], 32'hF000_0000);
    applyStimulus(32'h0800_0010, 0, 0, 1'b1, 1'bx, 1'b0);
    checkOutput("jump region B", pcOut[1], 32'hF000_0040);
    checkOutput("jump region A", pcOut[0], 32'h0000_0040);

    applyStimulus(32'h1000_0003, 0, 5, 1'b0, 1'b1, 1'b1);
    checkOutput("stall then branch", pcOut[0], 32'h0000_0050);

    applyStimulus(32'h0BFF_FFFF, 0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("top pc B", pcOut[1], 32'hFFFF_FFFC);
    checkOutput("pc_plus4 wraps", pcPlus4Out[1], 32'h0000_0000);
    applyStimulus(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("seq wrap B", pcOut[1], 32'h0000_0000);
    checkOutput("seq A", pcOut[0], 32'h1000_0000);

    checkOutput("req before reset", {31'b0, imemReq[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async req A", {31'b0, imemReq[0]}, 32'd0);
    checkOutput("async req B", {31'b0, imemReq[1]}, 32'd0);
    checkOutput("async pc", pcOut[0], 32'h0000_0040);
    @(negedge clk); #1;
    rst       = 1'b0;
    imemAck   = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    imemAck   = 1'b0;
    checkOutput("restart req", {31'b0, imemReq[0]}, 32'd1);
    checkOutput("restart addr", imemAddr[0], 32'h0000_0040);
    checkOutput("late ack ignored", instrOut[0], 32'h0000_0000);
    checkOutput("late ack no valid", {31'b0, instrValid[0]}, 32'd0);
    applyStimulus(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("post reset seq A", pcOut[0], 32'h0000_0044);
    checkOutput("post reset seq B", pcOut[1], 32'hF000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
